// File: rtl/fft_in_loader.sv
// Input stage for the FFT working buffer: accepts a valid/ready sample stream and
// writes each sample at the (optionally bit-reversed) address of its arrival index.
module fft_in_loader #(
  parameter int LOG2N  = 11,
  parameter bit BITREV = 1'b1,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [15:0]       i_s_re,
  input  logic [15:0]       i_s_im,
  output logic              o_ram_ce,
  output logic              o_ram_oce,
  output logic              o_ram_wre,
  output logic [ADDR_W-1:0] o_ram_ad,
  output logic [31:0]       o_ram_din,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [LOG2N:0]    o_sample_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LOG2N:0] LAST_IDX = (LOG2N+1)'((1 << LOG2N) - 1);

  state_t              r_state;
  state_t              w_next;
  logic [LOG2N:0]      r_cnt;
  logic                r_ce;
  logic                r_wre;
  logic [ADDR_W-1:0]   r_ad;
  logic [31:0]         r_din;
  logic [LOG2N-1:0]    w_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_take;
  logic                w_launch;

  // The sample counter doubles as the arrival index of the next sample.
  assign w_idx    = r_cnt[LOG2N-1:0];
  assign w_launch = (r_state == IDLE) && i_start && !i_abort;
  assign w_take   = (r_state == LOAD) && i_s_valid && !i_abort;

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      if (BITREV) w_addr[i] = w_idx[LOG2N-1-i];
      else        w_addr[i] = w_idx[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_s_ready    = 1'b0;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) w_next = LOAD;
      end
      LOAD: begin
        o_s_ready = 1'b1;
        o_busy    = 1'b1;
        if (i_abort)                             w_next = IDLE;
        else if (i_s_valid && r_cnt == LAST_IDX) w_next = DONE;
      end
      DONE: begin
        o_busy       = 1'b1;
        o_frame_done = !i_abort;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Writes are registered so the buffer sees them one cycle after the handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
      r_wre <= 1'b0;
      r_ad  <= '0;
      r_din <= '0;
    end else begin
      r_ce  <= 1'b0;
      r_wre <= 1'b0;
      if (w_launch) begin
        r_cnt <= '0;
      end else if (r_state != IDLE && i_abort) begin
        r_cnt <= '0;
      end else if (w_take) begin
        r_cnt <= r_cnt + 1'b1;
        r_ce  <= 1'b1;
        r_wre <= 1'b1;
        r_ad  <= w_addr;
        r_din <= {i_s_re, i_s_im};
      end
    end
  end

  assign o_ram_ce     = r_ce;
  assign o_ram_oce    = 1'b0;
  assign o_ram_wre    = r_wre;
  assign o_ram_ad     = r_ad;
  assign o_ram_din    = r_din;
  assign o_sample_cnt = r_cnt;

endmodule

// File: tb/tb_fft_in_loader.sv
// Bench for fft_in_loader: an 8-point and a 2048-point instance share one stimulus
// stream; a selector picks which instance is compared against the reference model.
module tb_fft_in_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_re = '0;
  logic [15:0] s_im = '0;

  logic        aReady, aCe, aOce, aWre, aBusy, aFd;
  logic [10:0] aAd;
  logic [31:0] aDin;
  logic [3:0]  aCnt;
  logic        bReady, bCe, bOce, bWre, bBusy, bFd;
  logic [10:0] bAd;
  logic [31:0] bDin;
  logic [11:0] bCnt;

  int          tests = 0;
  int          failures = 0;
  bit          sel = 1'b0;
  logic [31:0] dutMem [0:2047];
  int          addrOf [0:2047];

  logic        obsReady, obsCe, obsOce, obsWre, obsBusy, obsFd;
  logic [31:0] obsAd, obsDin, obsCnt;

  always #5 clk = ~clk;

  fft_in_loader #(.LOG2N(3), .BITREV(1'b1), .ADDR_W(11)) dutSmall (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_s_valid(s_valid), .o_s_ready(aReady), .i_s_re(s_re), .i_s_im(s_im),
    .o_ram_ce(aCe), .o_ram_oce(aOce), .o_ram_wre(aWre), .o_ram_ad(aAd),
    .o_ram_din(aDin), .o_busy(aBusy), .o_frame_done(aFd), .o_sample_cnt(aCnt)
  );

  fft_in_loader #(.LOG2N(11), .BITREV(1'b1), .ADDR_W(11)) dutBig (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_s_valid(s_valid), .o_s_ready(bReady), .i_s_re(s_re), .i_s_im(s_im),
    .o_ram_ce(bCe), .o_ram_oce(bOce), .o_ram_wre(bWre), .o_ram_ad(bAd),
    .o_ram_din(bDin), .o_busy(bBusy), .o_frame_done(bFd), .o_sample_cnt(bCnt)
  );

  always_comb begin
    obsReady = sel ? bReady : aReady;
    obsCe    = sel ? bCe    : aCe;
    obsOce   = sel ? bOce   : aOce;
    obsWre   = sel ? bWre   : aWre;
    obsBusy  = sel ? bBusy  : aBusy;
    obsFd    = sel ? bFd    : aFd;
    obsAd    = sel ? {21'd0, bAd}  : {21'd0, aAd};
    obsDin   = sel ? bDin : aDin;
    obsCnt   = sel ? {20'd0, bCnt} : {28'd0, aCnt};
  end

  // Reference address: the arrival index read with its LOG2N bits in reverse order.
  function automatic int modelAddr(input int k, input int log2n);
    int r;
    int x;
    r = 0;
    x = k;
    repeat (log2n) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, obsReady}, 32'd0);
    checkOutput({tag, "_ce"},    {31'd0, obsCe},    32'd0);
    checkOutput({tag, "_wre"},   {31'd0, obsWre},   32'd0);
    checkOutput({tag, "_ad"},    obsAd,             32'd0);
    checkOutput({tag, "_din"},   obsDin,            32'd0);
    checkOutput({tag, "_busy"},  {31'd0, obsBusy},  32'd0);
    checkOutput({tag, "_fd"},    {31'd0, obsFd},    32'd0);
    checkOutput({tag, "_cnt"},   obsCnt,            32'd0);
  endtask

  // One frame: dataMode 0 = re=k/im=-k, 1 = random; gapMode 0 = none, 1 = alternate,
  // 2 = random gaps; abortAt = index to abort at (n = during DONE, -1 = never);
  // startAt = index at which a stray start is pulsed alongside the sample.
  task automatic applyStimulus(input int n, input int dataMode, input int gapMode,
                               input int abortAt, input int startAt);
    int          log2n;
    int          writes;
    int          gaps;
    logic [31:0] d;
    log2n  = sel ? 11 : 3;
    writes = 0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("startBusy", {31'd0, obsBusy}, 32'd1);
    checkOutput("startCnt",  obsCnt,           32'd0);
    for (int k = 0; k < n; k++) begin
      gaps = (gapMode == 1 && k > 0) ? 1 : (gapMode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("gapWre",  {31'd0, obsWre},  32'd0);
        checkOutput("gapCe",   {31'd0, obsCe},   32'd0);
        checkOutput("gapBusy", {31'd0, obsBusy}, 32'd1);
      end
      if (k == abortAt) begin
        s_valid = 1'b1;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        checkOutput("abortBusy",  {31'd0, obsBusy},  32'd0);
        checkOutput("abortWre",   {31'd0, obsWre},   32'd0);
        checkOutput("abortFd",    {31'd0, obsFd},    32'd0);
        checkOutput("abortCnt",   obsCnt,            32'd0);
        checkOutput("abortReady", {31'd0, obsReady}, 32'd0);
        return;
      end
      d       = (dataMode == 0) ? {16'(k), 16'(-k)} : $urandom();
      s_re    = d[31:16];
      s_im    = d[15:0];
      s_valid = 1'b1;
      start   = (k == startAt);
      #1;
      checkOutput("ready", {31'd0, obsReady}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("wre",    {31'd0, obsWre}, 32'd1);
      checkOutput("ce",     {31'd0, obsCe},  32'd1);
      checkOutput("oce",    {31'd0, obsOce}, 32'd0);
      checkOutput("addr",   obsAd,           32'(modelAddr(k, log2n)));
      checkOutput("din",    obsDin,          d);
      checkOutput("cnt",    obsCnt,          32'(k + 1));
      if (k < n - 1) checkOutput("fdEarly", {31'd0, obsFd}, 32'd0);
      if (obsWre === 1'b1) begin
        writes++;
        dutMem[obsAd[10:0]] = obsDin;
        addrOf[k] = int'(obsAd);
      end
    end
    s_valid = 1'b0;
    if (abortAt == n) abort = 1'b1;
    #1;
    checkOutput("doneReady", {31'd0, obsReady}, 32'd0);
    checkOutput("doneBusy",  {31'd0, obsBusy},  32'd1);
    checkOutput("doneFd",    {31'd0, obsFd},    (abortAt == n) ? 32'd0 : 32'd1);
    checkOutput("writes",    32'(writes),       32'(n));
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("postBusy", {31'd0, obsBusy}, 32'd0);
    checkOutput("postFd",   {31'd0, obsFd},   32'd0);
    checkOutput("postWre",  {31'd0, obsWre},  32'd0);
    checkOutput("postCnt",  obsCnt,           (abortAt == n) ? 32'd0 : 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) dutMem[i] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back directed frame, then the same with alternating gaps
    applyStimulus(8, 0, 0, -1, -1);
    checkOutput("mem4", dutMem[4], 32'h0001_FFFF);
    dutMem[4] = 32'hDEAD_BEEF;
    applyStimulus(8, 0, 1, -1, -1);
    checkOutput("mem4Gap", dutMem[4], 32'h0001_FFFF);

    // Random data with random gaps
    applyStimulus(8, 1, 2, -1, -1);
    applyStimulus(8, 1, 2, -1, -1);

    // Abort after 5 samples, then a fresh frame from index 0
    applyStimulus(8, 1, 0, 5, -1);
    applyStimulus(8, 1, 0, -1, -1);

    // Abort coinciding with DONE suppresses frame_done
    applyStimulus(8, 1, 2, 8, -1);

    // Stray start during LOAD, then start+abort together in IDLE
    applyStimulus(8, 1, 0, -1, 3);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startAbortBusy",  {31'd0, obsBusy},  32'd0);
    checkOutput("startAbortReady", {31'd0, obsReady}, 32'd0);

    // Asynchronous reset mid-frame
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_re    = 16'($urandom());
      s_im    = 16'($urandom());
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8, 0, 0, -1, -1);

    // Full 2048-point frame on the large instance
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b1;
    #1;
    checkAllZero("bigReset");
    applyStimulus(2048, 1, 0, -1, -1);
    checkOutput("bigIdx1",    32'(addrOf[1]),    32'd1024);
    checkOutput("bigIdx2047", 32'(addrOf[2047]), 32'd2047);
    checkOutput("bigIdx1023", 32'(addrOf[1023]), 32'd2046);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
